// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: requester, ALU and CDB signals of the ALU issue arbiter
interface alu_issue_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*32-1:0]    req_a;
   logic [NUM_REQ*32-1:0]    req_b;
   logic [NUM_REQ*4-1:0]     req_op;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [31:0]              alu_a;
   logic [31:0]              alu_b;
   logic [3:0]               alu_control;
   logic [31:0]              alu_result;
   logic                     alu_zero;
   logic                     cdb_valid;
   logic                     cdb_ready;
   logic [31:0]              cdb_result;
   logic                     cdb_zero;
   logic [TAG_W-1:0]         cdb_tag;
   logic                     busy;
   modport master (
      output req_valid, req_a, req_b, req_op, req_tag, alu_result, alu_zero, cdb_ready,
      input  req_ready, alu_a, alu_b, alu_control, cdb_valid, cdb_result, cdb_zero, cdb_tag, busy
   );
   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag, alu_result, alu_zero, cdb_ready,
      output req_ready, alu_a, alu_b, alu_control, cdb_valid, cdb_result, cdb_zero, cdb_tag, busy
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of requester ops to a shared ALU, two-stage EX/WB pipeline to the CDB
module alu_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6
) (
   input logic               clk,
   input logic               rst,
   alu_issue_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   logic [PW-1:0]      r_rr_ptr;
   logic               r_ex_valid;
   logic [31:0]        r_ex_a;
   logic [31:0]        r_ex_b;
   logic [3:0]         r_ex_op;
   logic [TAG_W-1:0]   r_ex_tag;
   logic               r_cdb_valid;
   logic [31:0]        r_cdb_result;
   logic               r_cdb_zero;
   logic [TAG_W-1:0]   r_cdb_tag;
   logic               w_wb_free;
   logic               w_ex_free;
   logic               w_any;
   logic               w_acc;
   logic               w_adv;
   logic [PW-1:0]      w_gidx;
   logic [NUM_REQ-1:0] w_grant;
   assign w_wb_free = !r_cdb_valid | bus.cdb_ready;
   assign w_ex_free = !r_ex_valid | w_wb_free;
   assign w_any     = |bus.req_valid;
   assign w_acc     = w_any & w_ex_free;
   assign w_adv     = r_ex_valid & w_wb_free;
   // scan downward so the lowest offset from r_rr_ptr wins
   always_comb begin
      w_gidx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) w_gidx = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
   end
   assign w_grant       = w_any ? NUM_REQ'(1) << w_gidx : '0;
   assign bus.req_ready = w_ex_free ? w_grant : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr     <= '0;
         r_ex_valid   <= 1'b0;
         r_ex_a       <= '0;
         r_ex_b       <= '0;
         r_ex_op      <= '0;
         r_ex_tag     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_result <= '0;
         r_cdb_zero   <= 1'b0;
         r_cdb_tag    <= '0;
      end else begin
         if (w_acc) begin
            r_ex_valid <= 1'b1;
            r_ex_a     <= bus.req_a[32*w_gidx +: 32];
            r_ex_b     <= bus.req_b[32*w_gidx +: 32];
            r_ex_op    <= bus.req_op[4*w_gidx +: 4];
            r_ex_tag   <= bus.req_tag[TAG_W*w_gidx +: TAG_W];
            r_rr_ptr   <= w_gidx == PW'(NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
         end else if (w_adv) begin
            r_ex_valid <= 1'b0;
         end
         if (w_adv) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_result <= bus.alu_result;
            r_cdb_zero   <= bus.alu_zero;
            r_cdb_tag    <= r_ex_tag;
         end else if (bus.cdb_ready) begin
            r_cdb_valid <= 1'b0;
         end
      end
   end
   assign bus.alu_a       = r_ex_a;
   assign bus.alu_b       = r_ex_b;
   assign bus.alu_control = r_ex_op;
   assign bus.cdb_valid   = r_cdb_valid;
   assign bus.cdb_result  = r_cdb_result;
   assign bus.cdb_zero    = r_cdb_zero;
   assign bus.cdb_tag     = r_cdb_tag;
   assign bus.busy        = r_ex_valid | r_cdb_valid;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: vector table, directed pipeline sequences and a CDB scoreboard for alu_issue_arbiter
module tb_alu_issue_arbiter;
   localparam int NUM_REQ = 4;
   localparam int TAG_W   = 6;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                          SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
   logic clk = 1'b0;
   logic rst;
   logic [31:0]      pa [NUM_REQ];
   logic [31:0]      pb [NUM_REQ];
   logic [3:0]       pop [NUM_REQ];
   logic [TAG_W-1:0] ptag [NUM_REQ];
   logic [NUM_REQ-1:0] pv;
   int n_chk = 0;
   int n_pass = 0;
   typedef struct {
      logic [31:0]      res;
      logic             z;
      logic [TAG_W-1:0] tag;
   } exp_t;
   exp_t sb[$];
   typedef struct {
      logic [3:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
      logic             z;
   } vec_t;
   vec_t vt[8];
   alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus();
   alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         AND_:    return a & b;
         OR_:     return a | b;
         XOR_:    return a ^ b;
         SLL:     return a << b[4:0];
         SRL:     return a >> b[4:0];
         SRA:     return $signed(a) >>> b[4:0];
         SLT:     return {31'b0, $signed(a) < $signed(b)};
         SLTU:    return {31'b0, a < b};
         default: return 32'b0;
      endcase
   endfunction
   assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_control);
   assign bus.alu_zero   = bus.alu_result == 32'b0;
   always_comb begin
      bus.req_valid = pv;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.req_tag   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_a[32*i +: 32]       = pa[i];
         bus.req_b[32*i +: 32]       = pb[i];
         bus.req_op[4*i +: 4]        = pop[i];
         bus.req_tag[TAG_W*i +: TAG_W] = ptag[i];
      end
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic set_req(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
      pop[i]  = op;
      pa[i]   = a;
      pb[i]   = b;
      ptag[i] = tag;
      pv[i]   = 1'b1;
   endtask
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask
   always @(posedge rst) sb.delete();
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cdb_valid && bus.cdb_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL sb_underflow: got tag %0d with no expected entry", bus.cdb_tag);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_result", bus.cdb_result, e.res);
               chk("sb_zero", 32'(bus.cdb_zero), 32'(e.z));
               chk("sb_tag", 32'(bus.cdb_tag), 32'(e.tag));
            end
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready[i]) begin
               logic [31:0] r;
               r = ref_alu(pa[i], pb[i], pop[i]);
               sb.push_back('{r, r == 32'b0, ptag[i]});
            end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      vt[0] = '{SUB,  32'd9,        32'd9,        6'd10, 32'h0,        1'b1};
      vt[1] = '{SRA,  32'h80000000, 32'd4,        6'd11, 32'hF8000000, 1'b0};
      vt[2] = '{4'hF, 32'd123,      32'd45,       6'd12, 32'h0,        1'b1};
      vt[3] = '{XOR_, 32'hFF00FF00, 32'h0F0F0F0F, 6'd13, 32'hF00FF00F, 1'b0};
      vt[4] = '{SLL,  32'd1,        32'd31,       6'd14, 32'h80000000, 1'b0};
      vt[5] = '{SLT,  32'hFFFFFFFF, 32'd1,        6'd15, 32'h1,        1'b0};
      vt[6] = '{SLTU, 32'hFFFFFFFF, 32'd1,        6'd16, 32'h0,        1'b1};
      vt[7] = '{AND_, 32'h0000F0F0, 32'h0000FF00, 6'd17, 32'h0000F000, 1'b0};
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD, 32'd0, 32'd0, '0);
      pv = '0;
      rst = 1'b1;
      bus.cdb_ready = 1'b0;
      @(negedge clk);
      chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_cdb_result", bus.cdb_result, 32'd0);
      chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
      next_cycle();
      rst = 1'b0;
      bus.cdb_ready = 1'b1;
      @(negedge clk);
      chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
      set_req(2, ADD, 32'd5, 32'd7, 6'd3);
      @(negedge clk);
      chk("lat_req_ready", 32'(bus.req_ready), 32'b0100);
      next_cycle();
      pv = '0;
      @(posedge clk);
      @(negedge clk);
      chk("lat_cdb_valid", 32'(bus.cdb_valid), 32'd1);
      chk("lat_cdb_result", bus.cdb_result, 32'd12);
      chk("lat_cdb_tag", 32'(bus.cdb_tag), 32'd3);
      chk("lat_cdb_zero", 32'(bus.cdb_zero), 32'd0);
      chk("lat_rr_ptr", 32'(dut.r_rr_ptr), 32'd3);
      next_cycle();
      for (int v = 0; v < 8; v++) begin
         int i;
         i = v % NUM_REQ;
         set_req(i, vt[v].op, vt[v].a, vt[v].b, vt[v].tag);
         @(negedge clk);
         chk($sformatf("vec%0d_req_ready", v), 32'(bus.req_ready), 32'(1) << i);
         next_cycle();
         pv = '0;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_result", v), bus.cdb_result, vt[v].res);
         chk($sformatf("vec%0d_zero", v), 32'(bus.cdb_zero), 32'(vt[v].z));
         chk($sformatf("vec%0d_tag", v), 32'(bus.cdb_tag), 32'(vt[v].tag));
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADD, 32'(i), 32'd100, 6'(20 + i));
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", c), 32'(bus.req_ready), 32'(1) << (c % NUM_REQ));
         if (c >= 2) begin
            chk($sformatf("rr_cdb_valid%0d", c), 32'(bus.cdb_valid), 32'd1);
            chk($sformatf("rr_cdb_tag%0d", c), 32'(bus.cdb_tag), 32'(20 + (c - 2) % NUM_REQ));
         end
         next_cycle();
      end
      pv = '0;
      repeat (3) next_cycle();
      bus.cdb_ready = 1'b0;
      for (int i = 0; i < 3; i++) set_req(i, ADD, 32'(i), 32'd100, 6'(30 + i));
      @(negedge clk);
      chk("bp_acc0", 32'(bus.req_ready), 32'b0001);
      next_cycle();
      pv[0] = 1'b0;
      @(negedge clk);
      chk("bp_acc1", 32'(bus.req_ready), 32'b0010);
      next_cycle();
      pv[1] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("bp_stall_ready%0d", c), 32'(bus.req_ready), 32'd0);
         chk($sformatf("bp_stall_valid%0d", c), 32'(bus.cdb_valid), 32'd1);
         chk($sformatf("bp_stall_tag%0d", c), 32'(bus.cdb_tag), 32'd30);
         chk($sformatf("bp_stall_result%0d", c), bus.cdb_result, 32'd100);
         chk($sformatf("bp_stall_busy%0d", c), 32'(bus.busy), 32'd1);
         next_cycle();
      end
      bus.cdb_ready = 1'b1;
      @(negedge clk);
      chk("bp_acc2", 32'(bus.req_ready), 32'b0100);
      next_cycle();
      pv[2] = 1'b0;
      @(negedge clk);
      chk("bp_retire_tag31", 32'(bus.cdb_tag), 32'd31);
      next_cycle();
      @(negedge clk);
      chk("bp_retire_tag32", 32'(bus.cdb_tag), 32'd32);
      next_cycle();
      repeat (3) next_cycle();
      bus.cdb_ready = 1'b0;
      set_req(0, OR_, 32'h1, 32'h2, 6'd40);
      set_req(1, OR_, 32'h4, 32'h8, 6'd41);
      @(negedge clk);
      chk("mr_acc0", 32'(bus.req_ready), 32'b0001);
      next_cycle();
      pv[0] = 1'b0;
      @(negedge clk);
      chk("mr_acc1", 32'(bus.req_ready), 32'b0010);
      next_cycle();
      pv = '0;
      @(negedge clk);
      chk("mr_full_busy", 32'(bus.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("mr_ex_valid", 32'(dut.r_ex_valid), 32'd0);
      chk("mr_busy", 32'(bus.busy), 32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      bus.cdb_ready = 1'b1;
      set_req(1, ADD, 32'd1, 32'd1, 6'd42);
      set_req(3, ADD, 32'd3, 32'd3, 6'd43);
      @(negedge clk);
      chk("mr_first_grant", 32'(bus.req_ready), 32'b0010);
      next_cycle();
      pv[1] = 1'b0;
      @(negedge clk);
      chk("mr_second_grant", 32'(bus.req_ready), 32'b1000);
      next_cycle();
      pv = '0;
      repeat (4) next_cycle();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
